// File: rtl/core_hazard_ctrl_pkg.sv
// core_hazard_ctrl_pkg: shared types and helpers for the pipeline hazard sequencer
package core_hazard_ctrl_pkg;
  typedef enum logic [0:0] {RUN = 1'b0, WAIT = 1'b1} hazard_state_t;
  typedef enum logic [1:0] {PC_PC4 = 2'd0, PC_BRANCH = 2'd1, PC_EXC = 2'd2, PC_EPC = 2'd3} pc_src_t;
  // Both source fields are compared whatever the opcode; a spurious stall only costs one bubble.
  function automatic logic load_use(input logic ld, input logic [4:0] w, input logic [4:0] rs, input logic [4:0] rt);
    return ld && w != 5'd0 && (w == rs || w == rt);
  endfunction
endpackage

// File: rtl/core_hazard_ctrl_if.sv
// core_hazard_ctrl_if: stage-register fields in, pipeline controls out; HAZARD_STATS_EN adds statistics
interface core_hazard_ctrl_if
`ifdef HAZARD_STATS_EN
  #(parameter int STAT_W = 32)
`endif
  ;
  import core_hazard_ctrl_pkg::*;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_load;
  logic [4:0] ex_W_regnum;
  logic       branch_taken;
  logic       eret;
  logic       exception;
  logic       dmem_req;
  logic       dmem_ready;
  logic       freeze;
  logic       stall_pc;
  logic       id_stall;
  logic       flush_if;
  logic       flush_id;
  logic       flush_ex;
  logic       flush_mem;
  pc_src_t    pc_src;
  logic       bus_error;
  logic       mem_wait;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles;
  logic [STAT_W-1:0] flush_events;
  logic [STAT_W-1:0] bus_errors;
`endif
  modport master (
    output id_rs, id_rt, ex_load, ex_W_regnum, branch_taken, eret, exception, dmem_req, dmem_ready,
    input  freeze, stall_pc, id_stall, flush_if, flush_id, flush_ex, flush_mem, pc_src, bus_error, mem_wait
`ifdef HAZARD_STATS_EN
    , input stall_cycles, flush_events, bus_errors
`endif
  );
  modport slave (
    input  id_rs, id_rt, ex_load, ex_W_regnum, branch_taken, eret, exception, dmem_req, dmem_ready,
    output freeze, stall_pc, id_stall, flush_if, flush_id, flush_ex, flush_mem, pc_src, bus_error, mem_wait
`ifdef HAZARD_STATS_EN
    , output stall_cycles, flush_events, bus_errors
`endif
  );
endinterface

// File: rtl/core_hazard_ctrl_wait_timer.sv
// core_hazard_ctrl_wait_timer: data-memory wait counter with saturation and watchdog expiry compare
module core_hazard_ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = MEM_TIMEOUT == 0 ? '0 : CNT_W'(MEM_TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt;
  // count frozen WAIT cycles, holding at all-ones; any other cycle restarts from zero
  always_ff @(posedge clock or posedge reset)
    if (reset) wait_cnt <= '0;
    else wait_cnt <= !inc ? '0 : &wait_cnt ? wait_cnt : wait_cnt + CNT_W'(1);
  assign expire = MEM_TIMEOUT != 0 && wait_cnt == LAST;
endmodule

// File: rtl/core_hazard_ctrl.sv
// core_hazard_ctrl: stall/flush/freeze/PC-select sequencer for the 5-stage core; HAZARD_STATS_EN adds counters
module core_hazard_ctrl
  import core_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 5
`ifdef HAZARD_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input logic clock,
  input logic reset,
  core_hazard_ctrl_if.slave hz
);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  logic [0:0] state;
  logic expire, timeout, kill, er, mw, br, lu;
  // Priority chain: each lower rule is masked by every rule above it.
  assign timeout = state == ST_WAIT && !hz.dmem_ready && expire;
  assign kill    = hz.exception || timeout;
  assign er      = !kill && hz.eret;
  assign mw      = !kill && !hz.eret && hz.dmem_req && !hz.dmem_ready;
  assign br      = !kill && !hz.eret && !mw && hz.branch_taken;
  assign lu      = !kill && !hz.eret && !mw && !hz.branch_taken &&
                   load_use(hz.ex_load, hz.ex_W_regnum, hz.id_rs, hz.id_rt);
  // Everything is forced quiet while reset is held, even though it is asynchronous.
  assign hz.freeze    = !reset && mw;
  assign hz.stall_pc  = !reset && lu;
  assign hz.id_stall  = !reset && lu;
  assign hz.flush_if  = !reset && (kill || er || br);
  assign hz.flush_id  = !reset && (kill || er || br);
  assign hz.flush_ex  = !reset && (kill || er);
  assign hz.flush_mem = !reset && kill;
  assign hz.bus_error = !reset && timeout;
  assign hz.mem_wait  = !reset && state == ST_WAIT;
  assign hz.pc_src    = reset ? PC_PC4 : kill ? PC_EXC : er ? PC_EPC : br ? PC_BRANCH : PC_PC4;
  // stay in WAIT only while an unmasked memory access is still outstanding
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= ST_RUN;
    else state <= mw ? ST_WAIT : ST_RUN;
  core_hazard_ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clock(clock),
    .reset(reset),
    .inc(mw && state == ST_WAIT),
    .expire(expire)
  );
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles, flush_events, bus_errors;
  // free-running event counters that wrap naturally
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
      bus_errors   <= '0;
    end else begin
      stall_cycles <= stall_cycles + STAT_W'(hz.freeze || hz.stall_pc);
      flush_events <= flush_events + STAT_W'(hz.flush_if || hz.flush_id || hz.flush_ex || hz.flush_mem);
      bus_errors   <= bus_errors + STAT_W'(hz.bus_error);
    end
  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_events = flush_events;
  assign hz.bus_errors   = bus_errors;
`endif
endmodule

// File: tb/tb_core_hazard_ctrl.sv
// tb_core_hazard_ctrl: directed self-checking bench; watchdog DUT (timeout 4) and watchdog-disabled DUT
module tb_core_hazard_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_W_regnum = '0;
  logic ex_load = 0, branch_taken = 0, eret = 0, exception = 0, dmem_req = 0, dmem_ready = 0;
  int checks = 0;
  int failures = 0;
  // {freeze, stall_pc, id_stall, flush_if, flush_id, flush_ex, flush_mem, pc_src, bus_error, mem_wait}
  localparam logic [10:0] O_IDLE  = 11'b0_00_0000_00_0_0;
  localparam logic [10:0] O_STALL = 11'b0_11_0000_00_0_0;
  localparam logic [10:0] O_BR    = 11'b0_00_1100_01_0_0;
  localparam logic [10:0] O_BR_W  = 11'b0_00_1100_01_0_1;
  localparam logic [10:0] O_FRZ   = 11'b1_00_0000_00_0_0;
  localparam logic [10:0] O_FRZ_W = 11'b1_00_0000_00_0_1;
  localparam logic [10:0] O_EXC   = 11'b0_00_1111_10_0_0;
  localparam logic [10:0] O_EXC_W = 11'b0_00_1111_10_0_1;
  localparam logic [10:0] O_TO_W  = 11'b0_00_1111_10_1_1;
  localparam logic [10:0] O_ERET  = 11'b0_00_1110_11_0_0;
  core_hazard_ctrl_if hz_a();
  core_hazard_ctrl_if hz_b();
  assign hz_a.id_rs = id_rs;
  assign hz_a.id_rt = id_rt;
  assign hz_a.ex_load = ex_load;
  assign hz_a.ex_W_regnum = ex_W_regnum;
  assign hz_a.branch_taken = branch_taken;
  assign hz_a.eret = eret;
  assign hz_a.exception = exception;
  assign hz_a.dmem_req = dmem_req;
  assign hz_a.dmem_ready = dmem_ready;
  assign hz_b.id_rs = id_rs;
  assign hz_b.id_rt = id_rt;
  assign hz_b.ex_load = ex_load;
  assign hz_b.ex_W_regnum = ex_W_regnum;
  assign hz_b.branch_taken = branch_taken;
  assign hz_b.eret = eret;
  assign hz_b.exception = exception;
  assign hz_b.dmem_req = dmem_req;
  assign hz_b.dmem_ready = dmem_ready;
  core_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (.clock(clock), .reset(reset), .hz(hz_a));
  core_hazard_ctrl #(.MEM_TIMEOUT(0), .CNT_W(3)) dut_nowd (.clock(clock), .reset(reset), .hz(hz_b));
  logic [10:0] outs_a, outs_b;
  assign outs_a = {hz_a.freeze, hz_a.stall_pc, hz_a.id_stall, hz_a.flush_if, hz_a.flush_id,
                   hz_a.flush_ex, hz_a.flush_mem, hz_a.pc_src, hz_a.bus_error, hz_a.mem_wait};
  assign outs_b = {hz_b.freeze, hz_b.stall_pc, hz_b.id_stall, hz_b.flush_if, hz_b.flush_id,
                   hz_b.flush_ex, hz_b.flush_mem, hz_b.pc_src, hz_b.bus_error, hz_b.mem_wait};
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic clear();
    id_rs = '0; id_rt = '0; ex_W_regnum = '0;
    ex_load = 0; branch_taken = 0; eret = 0; exception = 0; dmem_req = 0; dmem_ready = 0;
  endtask
  task automatic test_reset();
    exception = 1; dmem_req = 1; branch_taken = 1; ex_load = 1; ex_W_regnum = 5; id_rs = 5;
    #2;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs_a, O_IDLE); end
    clear();
    @(posedge clock); #1;
    reset = 0;
    #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL post_reset got=%b exp=%b", outs_a, O_IDLE); end
    tick();
  endtask
  task automatic test_load_use();
    ex_load = 1; ex_W_regnum = 5; id_rs = 3; id_rt = 5; #1;
    checks++; if (outs_a !== O_STALL) begin failures++; $display("FAIL lu_rt got=%b exp=%b", outs_a, O_STALL); end
    tick();
    ex_load = 0; ex_W_regnum = 0; #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL lu_bubble got=%b exp=%b", outs_a, O_IDLE); end
    tick();
    ex_load = 1; ex_W_regnum = 9; id_rs = 9; id_rt = 1; #1;
    checks++; if (outs_a !== O_STALL) begin failures++; $display("FAIL lu_rs got=%b exp=%b", outs_a, O_STALL); end
    tick();
    ex_W_regnum = 0; id_rs = 0; id_rt = 0; #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL lu_r0 got=%b exp=%b", outs_a, O_IDLE); end
    tick();
    ex_W_regnum = 7; id_rs = 6; id_rt = 8; #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL lu_nomatch got=%b exp=%b", outs_a, O_IDLE); end
    tick();
    ex_load = 0; ex_W_regnum = 4; id_rs = 4; #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL lu_noload got=%b exp=%b", outs_a, O_IDLE); end
    clear();
    tick();
  endtask
  task automatic test_branch();
    branch_taken = 1; ex_load = 1; ex_W_regnum = 5; id_rt = 5; #1;
    checks++; if (outs_a !== O_BR) begin failures++; $display("FAIL br_over_lu got=%b exp=%b", outs_a, O_BR); end
    clear();
    tick();
  endtask
  task automatic test_eret();
    eret = 1; branch_taken = 1; #1;
    checks++; if (outs_a !== O_ERET) begin failures++; $display("FAIL eret_over_br got=%b exp=%b", outs_a, O_ERET); end
    tick();
    branch_taken = 0; dmem_req = 1; #1;
    checks++; if (outs_a !== O_ERET) begin failures++; $display("FAIL eret_over_wait got=%b exp=%b", outs_a, O_ERET); end
    tick();
    exception = 1; #1;
    checks++; if (outs_a !== O_EXC) begin failures++; $display("FAIL exc_over_eret got=%b exp=%b", outs_a, O_EXC); end
    clear();
    tick();
    #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL eret_after got=%b exp=%b", outs_a, O_IDLE); end
    tick();
  endtask
  task automatic test_mem_wait();
    dmem_req = 1; #1;
    checks++; if (outs_a !== O_FRZ) begin failures++; $display("FAIL mw_c1 got=%b exp=%b", outs_a, O_FRZ); end
    tick();
    #1;
    checks++; if (outs_a !== O_FRZ_W) begin failures++; $display("FAIL mw_c2 got=%b exp=%b", outs_a, O_FRZ_W); end
    tick();
    #1;
    checks++; if (outs_a !== O_FRZ_W) begin failures++; $display("FAIL mw_c3 got=%b exp=%b", outs_a, O_FRZ_W); end
    tick();
    dmem_ready = 1; branch_taken = 1; #1;
    checks++; if (outs_a !== O_BR_W) begin failures++; $display("FAIL mw_ready got=%b exp=%b", outs_a, O_BR_W); end
    clear();
    tick();
    #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL mw_run got=%b exp=%b", outs_a, O_IDLE); end
    tick();
  endtask
  task automatic test_timeout();
    logic bad;
    dmem_req = 1; #1;
    checks++; if (outs_a !== O_FRZ) begin failures++; $display("FAIL to_c1 got=%b exp=%b", outs_a, O_FRZ); end
    for (int i = 2; i <= 4; i++) begin
      tick(); #1;
      checks++; if (outs_a !== O_FRZ_W) begin failures++; $display("FAIL to_c%0d got=%b exp=%b", i, outs_a, O_FRZ_W); end
    end
    tick(); #1;
    checks++; if (outs_a !== O_TO_W) begin failures++; $display("FAIL to_pulse got=%b exp=%b", outs_a, O_TO_W); end
    checks++; if (outs_b !== O_FRZ_W) begin failures++; $display("FAIL nowd_c5 got=%b exp=%b", outs_b, O_FRZ_W); end
    tick(); #1;
    checks++; if (outs_a !== O_FRZ) begin failures++; $display("FAIL to_restart got=%b exp=%b", outs_a, O_FRZ); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (outs_b !== O_FRZ_W) bad = 1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL nowd_hold got=%b exp=0", bad); end
    clear();
    tick();
  endtask
  task automatic test_exception_wait();
    dmem_req = 1; #1;
    checks++; if (outs_a !== O_FRZ) begin failures++; $display("FAIL exw_c1 got=%b exp=%b", outs_a, O_FRZ); end
    tick(); #1;
    checks++; if (outs_a !== O_FRZ_W) begin failures++; $display("FAIL exw_c2 got=%b exp=%b", outs_a, O_FRZ_W); end
    tick();
    exception = 1; #1;
    checks++; if (outs_a !== O_EXC_W) begin failures++; $display("FAIL exw_exc got=%b exp=%b", outs_a, O_EXC_W); end
    clear();
    tick(); #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL exw_next got=%b exp=%b", outs_a, O_IDLE); end
    tick();
  endtask
  task automatic test_reset_mid_wait();
    dmem_req = 1;
    tick(); #1;
    checks++; if (outs_a !== O_FRZ_W) begin failures++; $display("FAIL rmw_wait got=%b exp=%b", outs_a, O_FRZ_W); end
    #3;
    reset = 1;
    #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL rmw_async got=%b exp=%b", outs_a, O_IDLE); end
`ifdef HAZARD_STATS_EN
    checks++; if ({hz_a.stall_cycles, hz_a.flush_events, hz_a.bus_errors} !== 96'd0) begin
      failures++; $display("FAIL rmw_stats got=%0d/%0d/%0d exp=0/0/0", hz_a.stall_cycles, hz_a.flush_events, hz_a.bus_errors);
    end
`endif
    tick();
    clear();
    reset = 0;
    #1;
    checks++; if (outs_a !== O_IDLE) begin failures++; $display("FAIL rmw_release got=%b exp=%b", outs_a, O_IDLE); end
    tick();
    dmem_req = 1; #1;
    checks++; if (outs_a !== O_FRZ) begin failures++; $display("FAIL rmw_run got=%b exp=%b", outs_a, O_FRZ); end
    tick(); tick(); tick(); tick(); #1;
    checks++; if (outs_a !== O_TO_W) begin failures++; $display("FAIL rmw_cnt0 got=%b exp=%b", outs_a, O_TO_W); end
    clear();
    tick();
  endtask
`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    reset = 1; #2;
    reset = 0; #1;
    checks++; if ({hz_a.stall_cycles, hz_a.flush_events, hz_a.bus_errors} !== 96'd0) begin
      failures++; $display("FAIL st_zero got=%0d/%0d/%0d exp=0/0/0", hz_a.stall_cycles, hz_a.flush_events, hz_a.bus_errors);
    end
    tick();
    ex_load = 1; ex_W_regnum = 3; id_rs = 3; tick(); clear();
    branch_taken = 1; tick(); clear();
    dmem_req = 1; tick(); tick();
    dmem_ready = 1; tick(); clear();
    exception = 1; tick(); clear(); #1;
    checks++; if ({hz_a.stall_cycles, hz_a.flush_events, hz_a.bus_errors} !== {32'd3, 32'd2, 32'd0}) begin
      failures++; $display("FAIL st_mix got=%0d/%0d/%0d exp=3/2/0", hz_a.stall_cycles, hz_a.flush_events, hz_a.bus_errors);
    end
    dmem_req = 1;
    for (int i = 0; i < 5; i++) tick();
    clear(); #1;
    checks++; if ({hz_a.stall_cycles, hz_a.flush_events, hz_a.bus_errors} !== {32'd7, 32'd3, 32'd1}) begin
      failures++; $display("FAIL st_timeout got=%0d/%0d/%0d exp=7/3/1", hz_a.stall_cycles, hz_a.flush_events, hz_a.bus_errors);
    end
    tick();
  endtask
`endif
  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_eret();
    test_mem_wait();
    test_timeout();
    test_exception_wait();
    test_reset_mid_wait();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
